seven_segment_capture_decoder: RTL and testbench

//   Decoder side of the two-digit hex seven-segment display path. Samples a pair
//   of active-low segment patterns and recovers the byte they show.

---
 rtl/seven_segment_capture_decoder_if.sv | 26 ++
 rtl/seven_segment_capture_decoder.sv | 157 +++++++++++++++
 tb/tb_seven_segment_capture_decoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_capture_decoder_if.sv
// Two-digit seven-segment capture bus: segment patterns in, recovered byte out.
interface seven_segment_capture_decoder_if;
    logic [6:0] indicator0;  // low-nibble digit, bit6..bit0 = g..a, active-low
    logic [6:0] indicator1;  // high-nibble digit, same encoding
    logic [7:0] data;
    logic       update;
    logic       error;

    // Pattern source side: drives segments, observes the decoded result.
    modport master (
        output indicator0,
        output indicator1,
        input  data,
        input  update,
        input  error
    );

    // Decoder side.
    modport slave (
        input  indicator0,
        input  indicator1,
        output data,
        output update,
        output error
    );
endinterface

// File: rtl/seven_segment_capture_decoder.sv
// Recovers a byte from two active-low seven-segment patterns. Inputs are
// synchronized, changes are debounced for STABLE_CYCLES, and each new stable
// pair is reported once: a one-cycle update strobe for valid hex glyphs, or a
// sticky error flag when either digit is not a hex glyph.
module seven_segment_capture_decoder #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input logic                          clk,
    input logic                          reset,
    seven_segment_capture_decoder_if.slave bus
);

    localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

    // "00" on both digits; matches the display's own power-on pattern.
    localparam logic [13:0] PairZero = {7'b1000000, 7'b1000000};

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StReport
    } state_e;

    // Returns {valid, nibble}; valid is low for any non-hex pattern.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b1000000: res = {1'b1, 4'h0};
            7'b1111001: res = {1'b1, 4'h1};
            7'b0100100: res = {1'b1, 4'h2};
            7'b0110000: res = {1'b1, 4'h3};
            7'b0011001: res = {1'b1, 4'h4};
            7'b0010010: res = {1'b1, 4'h5};
            7'b0000010: res = {1'b1, 4'h6};
            7'b1111000: res = {1'b1, 4'h7};
            7'b0000000: res = {1'b1, 4'h8};
            7'b0010000: res = {1'b1, 4'h9};
            7'b0001000: res = {1'b1, 4'hA};
            7'b0000011: res = {1'b1, 4'hB};
            7'b1000110: res = {1'b1, 4'hC};
            7'b0100001: res = {1'b1, 4'hD};
            7'b0000110: res = {1'b1, 4'hE};
            7'b0001110: res = {1'b1, 4'hF};
            default:    res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    logic [13:0]     meta_q;
    logic [13:0]     sync_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [13:0]     cand_q, cand_d;
    logic [13:0]     last_q, last_d;
    logic [7:0]      data_q, data_d;
    logic            update_q, update_d;
    logic            error_q, error_d;

    logic [4:0]      dec_hi;
    logic [4:0]      dec_lo;

    // Two-flop synchronizer on every segment bit; nothing downstream sees raw inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= PairZero;
            sync_q <= PairZero;
        end else begin
            meta_q <= {bus.indicator1, bus.indicator0};
            sync_q <= meta_q;
        end
    end

    // Decode the candidate pair; only consumed in StReport.
    always_comb begin
        dec_hi = glyph_decode(cand_q[13:7]);
        dec_lo = glyph_decode(cand_q[6:0]);
    end

    // Next-state and output logic for the debounce/report FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        last_d   = last_q;
        data_d   = data_q;
        update_d = 1'b0;
        error_d  = error_q;

        unique case (state_q)
            StIdle: begin
                if (sync_q != last_q) begin
                    cand_d  = sync_q;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end

            StSettle: begin
                if (sync_q != cand_q) begin
                    // Any movement restarts the stability window.
                    cand_d = sync_q;
                    cnt_d  = '0;
                end else if (cand_q == last_q) begin
                    // Glitch reverted to the reported pair: drop it silently.
                    state_d = StIdle;
                end else if (cnt_q == CntMax) begin
                    state_d = StReport;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StReport: begin
                last_d  = cand_q;
                state_d = StIdle;
                if (dec_hi[4] && dec_lo[4]) begin
                    data_d   = {dec_hi[3:0], dec_lo[3:0]};
                    update_d = 1'b1;
                    error_d  = 1'b0;
                end else begin
                    error_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            cand_q   <= PairZero;
            last_q   <= PairZero;
            data_q   <= 8'h00;
            update_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            last_q   <= last_d;
            data_q   <= data_d;
            update_q <= update_d;
            error_q  <= error_d;
        end
    end

    assign bus.data   = data_q;
    assign bus.update = update_q;
    assign bus.error  = error_q;

endmodule

// File: tb/tb_seven_segment_capture_decoder.sv
// Scoreboard bench: stimulus pushes expected report events (cycle, data,
// error, update); a negedge monitor pops one whenever update pulses or error
// changes and compares.
module tb_seven_segment_capture_decoder;

    localparam int unsigned Stable = 16;
    // Drive happens just after edge N; first sampling edge is N+1; report
    // register loads at edge N+1+Stable+3.
    localparam int Lat = Stable + 4;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic prev_err = 1'b0;

    typedef struct {
        int         at;
        logic [7:0] data;
        logic       err;
        logic       upd;
    } exp_t;

    exp_t exp_q[$];

    seven_segment_capture_decoder_if bus ();

    seven_segment_capture_decoder #(
        .STABLE_CYCLES(Stable)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Change inputs 1ns after a rising edge; returns that edge's cycle number.
    task automatic drive(input logic [6:0] hi, input logic [6:0] lo, output int n);
        @(posedge clk);
        #1;
        bus.indicator1 = hi;
        bus.indicator0 = lo;
        n = cyc;
    endtask

    task automatic push(input int at, input logic [7:0] d, input logic e, input logic u);
        exp_t x;
        x.at = at;
        x.data = d;
        x.err = e;
        x.upd = u;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Monitor: an event is an update pulse or any change of error.
    always @(negedge clk) begin
        if (reset) begin
            prev_err = 1'b0;
        end else if (bus.update || (bus.error != prev_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event_update", int'(bus.update), 0);
                check("unexpected_event_error", int'(bus.error), int'(prev_err));
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("event_cycle", cyc, x.at);
                check("event_data", int'(bus.data), int'(x.data));
                check("event_error", int'(bus.error), int'(x.err));
                check("event_update", int'(bus.update), int'(x.upd));
            end
            prev_err = bus.error;
        end
    end

    initial begin
        int n;

        reset = 1'b1;
        bus.indicator1 = seg(4'h0);
        bus.indicator0 = seg(4'h0);
        idle(2);
        #1;
        check("reset_data", int'(bus.data), 8'h00);
        check("reset_update", int'(bus.update), 0);
        check("reset_error", int'(bus.error), 0);
        reset = 1'b0;

        // 1: idle on "00" produces nothing.
        idle(50);
        #1;
        check("idle_data", int'(bus.data), 8'h00);
        check("idle_error", int'(bus.error), 0);

        // 2: first real value.
        drive(seg(4'h3), seg(4'hA), n);
        push(n + Lat, 8'h3A, 1'b0, 1'b1);
        idle(30);

        // 3: short excursion to 55 that returns to 3A is suppressed.
        drive(seg(4'h5), seg(4'h5), n);
        idle(9);
        drive(seg(4'h3), seg(4'hA), n);
        idle(40);
        #1;
        check("glitch_data", int'(bus.data), 8'h3A);

        // 4: blank low digit flags error, then a valid value clears it.
        drive(seg(4'h3), 7'b1111111, n);
        push(n + Lat, 8'h3A, 1'b1, 1'b0);
        idle(30);
        drive(seg(4'hF), seg(4'h0), n);
        push(n + Lat, 8'hF0, 1'b0, 1'b1);
        idle(30);

        // 5: bouncing every 5 cycles never reports; final hold does.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drive(seg(4'h1), seg(4'h2), n);
            else drive(seg(4'h3), seg(4'h4), n);
            idle(4);
        end
        drive(seg(4'h1), seg(4'h2), n);
        push(n + Lat, 8'h12, 1'b0, 1'b1);
        idle(30);

        // 6: reset in the middle of settling, then settle afresh after release.
        drive(seg(4'h7), seg(4'hE), n);
        idle(8);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_data", int'(bus.data), 8'h00);
        check("midreset_update", int'(bus.update), 0);
        check("midreset_error", int'(bus.error), 0);
        idle(2);
        #1;
        reset = 1'b0;
        n = cyc;
        push(n + Lat, 8'h7E, 1'b0, 1'b1);
        idle(30);
        #1;
        check("final_data", int'(bus.data), 8'h7E);

        idle(5);
        check("pending_events", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
